// File: rtl/step_dir_pkg.sv
// Shared types and sizing helpers for the step/direction generator.
package step_dir_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    STEP  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned StepDivDefault = 4;

  // Prescaler counter width; never below one bit so StepDiv=2 still builds.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  localparam int unsigned PrescWidth = presc_width(StepDivDefault);

endpackage

// File: rtl/step_rate_timer.sv
// Inter-step prescaler: expire pulses StepDiv-1 cycles after start.
module step_rate_timer
  import step_dir_pkg::*;
#(
  parameter int unsigned StepDiv = StepDivDefault,
  parameter int unsigned CntW    = PrescWidth
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expire
);

  logic [CntW-1:0] r_cnt;
  logic            r_expire;

  // Registered expire: load StepDiv-2 so the pulse lands on the last WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else if (start) begin
      r_cnt    <= CntW'(StepDiv - 2);
      r_expire <= (StepDiv == 2);
    end else begin
      if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
      r_expire <= (r_cnt == CntW'(1));
    end
  end

  assign expire = r_expire;

endmodule

// File: rtl/step_dir_generator.sv
// Drives rate-limited step/up_down pulses toward a handshaked target position.
// Optional abort input enabled by defining STEP_DIR_GENERATOR_ABORT_EN.
module step_dir_generator
  import step_dir_pkg::*;
#(
  parameter int unsigned Width    = 8,
  parameter int unsigned MaxValue = 255,
  parameter int unsigned StepDiv  = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef STEP_DIR_GENERATOR_ABORT_EN
  input  logic             abort,
`endif
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [Width-1:0] target,
  output logic             step,
  output logic             up_down,
  output logic [Width-1:0] position,
  output logic             busy,
  output logic             done
);

  localparam logic [Width-1:0] MaxPos = Width'(MaxValue);

  state_e           r_state;
  state_e           w_state_next;
  logic [Width-1:0] r_tgt;
  logic [Width-1:0] r_pos;
  logic [Width-1:0] w_pos_step;
  logic [Width-1:0] w_tgt_clamped;
  logic             r_up_down;
  logic             r_step;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;
  logic             w_accept;
  logic             w_abort;
  logic             w_expire;
  logic             w_timer_start;

`ifdef STEP_DIR_GENERATOR_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept      = target_valid && (r_state == IDLE);
  assign w_tgt_clamped = (target > MaxPos) ? MaxPos : target;
  assign w_timer_start = (r_state == STEP) && (w_state_next == WAIT);

  // Saturating position update so the counter mirror can never wrap.
  always_comb begin
    w_pos_step = r_pos;
    if (r_up_down && (r_pos < MaxPos)) begin
      w_pos_step = r_pos + Width'(1);
    end else if (!r_up_down && (r_pos != '0)) begin
      w_pos_step = r_pos - Width'(1);
    end
  end

  step_rate_timer #(
    .StepDiv (StepDiv),
    .CntW    (presc_width(StepDiv))
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (w_timer_start),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SETUP;
      SETUP:   w_state_next = (w_abort || (r_tgt == r_pos)) ? DONE : STEP;
      STEP:    w_state_next = (w_abort || (w_pos_step == r_tgt)) ? DONE : WAIT;
      WAIT: begin
        if (w_abort)       w_state_next = DONE;
        else if (w_expire) w_state_next = STEP;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tgt     <= '0;
      r_pos     <= '0;
      r_up_down <= 1'b1;
      r_step    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      if (w_accept) r_tgt <= w_tgt_clamped;
      if ((r_state == SETUP) && (w_state_next == STEP)) r_up_down <= (r_tgt > r_pos);
      if (r_state == STEP) r_pos <= w_pos_step;
      r_step  <= (w_state_next == STEP);
      r_busy  <= (w_state_next != IDLE);
      r_done  <= (w_state_next == DONE);
      r_ready <= (w_state_next == IDLE);
    end
  end

  assign target_ready = r_ready;
  assign step         = r_step;
  assign up_down      = r_up_down;
  assign position     = r_pos;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_step_dir_generator.sv
// Self-checking bench for step_dir_generator: vector table plus event scoreboard.
module tb_step_dir_generator;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid_a, ready_a, step_a, up_a, busy_a, done_a;
  logic [7:0] target_a, pos_a;
  logic       valid_b, ready_b, step_b, up_b, busy_b, done_b;
  logic [7:0] target_b, pos_b;
`ifdef STEP_DIR_GENERATOR_ABORT_EN
  logic       abort_a, abort_b;
`endif

  step_dir_generator #(.Width(8), .MaxValue(255), .StepDiv(DIV)) dut_a (
    .clk(clk), .rst(rst),
`ifdef STEP_DIR_GENERATOR_ABORT_EN
    .abort(abort_a),
`endif
    .target_valid(valid_a), .target_ready(ready_a), .target(target_a),
    .step(step_a), .up_down(up_a), .position(pos_a), .busy(busy_a), .done(done_a)
  );

  step_dir_generator #(.Width(8), .MaxValue(10), .StepDiv(DIV)) dut_b (
    .clk(clk), .rst(rst),
`ifdef STEP_DIR_GENERATOR_ABORT_EN
    .abort(abort_b),
`endif
    .target_valid(valid_b), .target_ready(ready_b), .target(target_b),
    .step(step_b), .up_down(up_b), .position(pos_b), .busy(busy_b), .done(done_b)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    bit          is_done;
    bit          up;
    int unsigned pos;
  } ev_t;

  ev_t sb[$];
  int unsigned steps_a = 0;
  bit          last_up_a = 1'b0;
  int unsigned steps_b = 0;
  int unsigned max_b   = 0;
  int unsigned model_pos = 0;

  // Scoreboard monitor for dut_a: every step/done must match the head expectation.
  always @(negedge clk) begin
    ev_t e;
    if (rst === 1'b0 && (step_a === 1'b1 || done_a === 1'b1)) begin
      if (step_a) begin
        steps_a++;
        last_up_a = up_a;
      end
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: step=%b done=%b at cycle %0d, expected no event", step_a, done_a, cyc);
      end else begin
        e = sb.pop_front();
        check("sb_cycle", 64'(cyc), 64'(e.cyc));
        check("sb_kind_done", 64'(done_a), 64'(e.is_done));
        check("sb_pos", 64'(pos_a), 64'(e.pos));
        if (!e.is_done) check("sb_dir", 64'(up_a), 64'(e.up));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (step_b === 1'b1) steps_b++;
      if (int'(pos_b) > int'(max_b)) max_b = int'(pos_b);
    end
  end

  task automatic push_move(input int unsigned n, input int unsigned from, input int unsigned to);
    int unsigned d;
    bit up;
    ev_t e;
    d  = (from > to) ? from - to : to - from;
    up = (to > from);
    for (int i = 0; i < int'(d); i++) begin
      e.cyc = n + 2 + i * DIV;
      e.is_done = 1'b0;
      e.up = up;
      e.pos = up ? from + i : from - i;
      sb.push_back(e);
    end
    e.cyc = (d == 0) ? n + 2 : n + 2 + (d - 1) * DIV + 1;
    e.is_done = 1'b1;
    e.up = up;
    e.pos = to;
    sb.push_back(e);
  endtask

  task automatic start_move_a(input logic [7:0] t, output int unsigned n);
    @(negedge clk);
    n = cyc;
    valid_a = 1'b1;
    target_a = t;
    push_move(n, model_pos, int'(t));
    @(negedge clk);
    valid_a = 1'b0;
    check("setup_busy", 64'(busy_a), 64'd1);
    check("setup_ready", 64'(ready_a), 64'd0);
  endtask

  task automatic wait_done_a(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_done_b(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  tgt;
    int unsigned steps;
    bit          up;
    logic [7:0]  fin;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned s0;
    int unsigned dn;
    bit seen;

    tbl[0] = '{8'd5,   5,   1'b1, 8'd5};
    tbl[1] = '{8'd2,   3,   1'b0, 8'd2};
    tbl[2] = '{8'd3,   1,   1'b1, 8'd3};
    tbl[3] = '{8'd3,   0,   1'b1, 8'd3};
    tbl[4] = '{8'd0,   3,   1'b0, 8'd0};
    tbl[5] = '{8'd0,   0,   1'b0, 8'd0};
    tbl[6] = '{8'd255, 255, 1'b1, 8'd255};
    tbl[7] = '{8'd254, 1,   1'b0, 8'd254};
    tbl[8] = '{8'd255, 1,   1'b1, 8'd255};

    rst = 1'b1;
    valid_a = 1'b0; target_a = '0;
    valid_b = 1'b0; target_b = '0;
`ifdef STEP_DIR_GENERATOR_ABORT_EN
    abort_a = 1'b0; abort_b = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_position", 64'(pos_a), 64'd0);
    check("rst_step", 64'(step_a), 64'd0);
    check("rst_up_down", 64'(up_a), 64'd1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_ready", 64'(ready_a), 64'd1);
    rst = 1'b0;

    // Clamp: MaxValue=10 instance, 0 -> 8 then 200 (clamped to 10).
    @(negedge clk);
    valid_b = 1'b1; target_b = 8'd8;
    @(negedge clk);
    valid_b = 1'b0;
    wait_done_b(seen);
    check("b_first_done_seen", 64'(seen), 64'd1);
    check("b_first_pos", 64'(pos_b), 64'd8);
    @(negedge clk);
    s0 = steps_b;
    valid_b = 1'b1; target_b = 8'd200;
    @(negedge clk);
    valid_b = 1'b0;
    wait_done_b(seen);
    check("b_clamp_done_seen", 64'(seen), 64'd1);
    check("b_clamp_steps", 64'(steps_b - s0), 64'd2);
    check("b_clamp_pos", 64'(pos_b), 64'd10);
    check("b_clamp_dir", 64'(up_b), 64'd1);
    @(negedge clk);
    check("b_max_pos", 64'(max_b), 64'd10);
    check("b_idle_busy", 64'(busy_b), 64'd0);
    check("b_idle_ready", 64'(ready_b), 64'd1);

    // Table-driven moves on the full-range instance.
    for (int i = 0; i < 9; i++) begin
      s0 = steps_a;
      start_move_a(tbl[i].tgt, n);
      wait_done_a(seen);
      check("vec_done_seen", 64'(seen), 64'd1);
      check("vec_busy_in_done", 64'(busy_a), 64'd1);
      model_pos = int'(tbl[i].tgt);
      check("vec_steps", 64'(steps_a - s0), 64'(tbl[i].steps));
      check("vec_final_pos", 64'(pos_a), 64'(tbl[i].fin));
      if (tbl[i].steps > 0) check("vec_dir", 64'(last_up_a), 64'(tbl[i].up));
      @(negedge clk);
      check("vec_sb_drained", 64'(sb.size()), 64'd0);
      check("vec_idle_ready", 64'(ready_a), 64'd1);
      check("vec_idle_busy", 64'(busy_a), 64'd0);
    end

    // target_valid held through a move: second target taken only in first IDLE cycle after done.
    @(negedge clk);
    n = cyc;
    valid_a = 1'b1; target_a = 8'd252;
    push_move(n, 255, 252);
    push_move(n + 12, 252, 9);
    @(negedge clk);
    target_a = 8'd9;
    for (int k = 0; k < 11; k++) begin
      check("held_ready_low", 64'(ready_a), 64'd0);
      @(negedge clk);
    end
    check("held_ready_idle", 64'(ready_a), 64'd1);
    @(negedge clk);
    valid_a = 1'b0;
    check("held_accept_busy", 64'(busy_a), 64'd1);
    wait_done_a(seen);
    check("held_done_seen", 64'(seen), 64'd1);
    check("held_final_pos", 64'(pos_a), 64'd9);
    model_pos = 9;
    @(negedge clk);
    check("held_sb_drained", 64'(sb.size()), 64'd0);

    // Reset during WAIT abandons the move with no done pulse.
    @(negedge clk);
    n = cyc;
    valid_a = 1'b1; target_a = 8'd20;
    push_move(n, 9, 20);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_pos", 64'(pos_a), 64'd0);
    check("midrst_step", 64'(step_a), 64'd0);
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_done", 64'(done_a), 64'd0);
    check("midrst_ready", 64'(ready_a), 64'd1);
    rst = 1'b0;
    model_pos = 0;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_a === 1'b1 || step_a === 1'b1) dn++;
    end
    check("midrst_no_events", 64'(dn), 64'd0);

`ifdef STEP_DIR_GENERATOR_ABORT_EN
    // Abort during WAIT: done next cycle, position frozen after the single step.
    begin
      ev_t e;
      @(negedge clk);
      n = cyc;
      s0 = steps_a;
      valid_a = 1'b1; target_a = 8'd20;
      e.cyc = n + 2; e.is_done = 1'b0; e.up = 1'b1; e.pos = 0;
      sb.push_back(e);
      e.cyc = n + 4; e.is_done = 1'b1; e.up = 1'b1; e.pos = 1;
      sb.push_back(e);
      @(negedge clk);
      valid_a = 1'b0;
      repeat (2) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      check("abort_done", 64'(done_a), 64'd1);
      check("abort_pos", 64'(pos_a), 64'd1);
      repeat (10) @(negedge clk);
      check("abort_steps", 64'(steps_a - s0), 64'd1);
      check("abort_pos_frozen", 64'(pos_a), 64'd1);
      check("abort_sb_drained", 64'(sb.size()), 64'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
